// File: rtl/pipeline_pkg.sv
// Shared opcode, size-code and FSM state definitions for the load/store stage.
package pipeline_pkg;

  localparam logic [6:0] NOP   = 7'd0;
  localparam logic [6:0] LOAD  = 7'd1;
  localparam logic [6:0] STORE = 7'd2;
  localparam logic [6:0] ALU   = 7'd3;

  typedef enum logic [3:0] {
    BYTE               = 4'd0,
    HALF_WORD          = 4'd1,
    WORD               = 4'd2,
    DOUBLE_WORD        = 4'd3,
    UNSIGNED_WORD      = 4'd4,
    UNSIGNED_HALF_WORD = 4'd5,
    UNSIGNED_BYTE      = 4'd6
  } size_e;

  typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, WR_WAIT, DONE} state_e;

endpackage

// File: rtl/lsu_extend.sv
// Size-code decode: byte count, legality, and zero/sign-extended views of a datum.
module lsu_extend
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [3:0]            size,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [3:0]            nbytes,
  output logic                  legal,
  output logic [DATA_WIDTH-1:0] zext,
  output logic [DATA_WIDTH-1:0] sext
);

  logic                  is_signed;
  logic                  sign;
  logic [DATA_WIDTH-1:0] mask;

  always_comb begin
    nbytes    = 4'd0;
    legal     = 1'b1;
    is_signed = 1'b0;
    case (size)
      BYTE:               begin nbytes = 4'd1; is_signed = 1'b1; end
      HALF_WORD:          begin nbytes = 4'd2; is_signed = 1'b1; end
      WORD:               begin nbytes = 4'd4; is_signed = 1'b1; end
      DOUBLE_WORD:        begin nbytes = 4'd8; is_signed = 1'b1; legal = (DATA_WIDTH == 64); end
      UNSIGNED_WORD:      nbytes = 4'd4;
      UNSIGNED_HALF_WORD: nbytes = 4'd2;
      UNSIGNED_BYTE:      nbytes = 4'd1;
      default:            legal = 1'b0;
    endcase

    mask = '0;
    for (int i = 0; i < DATA_WIDTH/8; i++)
      if (i < int'(nbytes)) mask[i*8 +: 8] = 8'hFF;

    // mask is a contiguous run of low ones, so mask ^ (mask >> 1) isolates its MSB
    sign = is_signed && |(data & (mask ^ (mask >> 1)));
    zext = data & mask;
    sext = sign ? (zext | ~mask) : zext;
  end

endmodule

// File: rtl/pipeline_lsu.sv
// Memory stage: ALU writeback, loads over the read channel, stores over the write channel.
module pipeline_lsu
  import pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [3:0]            mem_operation_size,
  input  logic [DATA_WIDTH-1:0] ex_res,
  input  logic [DATA_WIDTH-1:0] r2_val,
  input  logic [4:0]            dst_reg,
  input  logic                  ecall,
  output logic                  ready,
  output logic                  wb_enable,
  output logic [4:0]            wb_dst_reg,
  output logic [DATA_WIDTH-1:0] wb_dst_val,
  output logic                  ecall_wb,
  output logic                  mem_fault,
  output logic [ADDR_WIDTH-1:0] S_R_ADDR,
  output logic                  S_R_ADDR_VALID,
  input  logic [DATA_WIDTH-1:0] S_R_DATA,
  input  logic                  S_R_DATA_VALID,
  output logic                  S_W_VALID,
  output logic [ADDR_WIDTH-1:0] S_W_ADDR,
  output logic [DATA_WIDTH-1:0] S_W_DATA,
  output logic [3:0]            S_W_SIZE,
  input  logic                  S_W_READY,
  input  logic                  S_W_COMPLETE
);

  state_e                state, state_n;
  logic [3:0]            size_q;
  logic [4:0]            ld_dst;
  logic [3:0]            ext_size;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [3:0]            nbytes;
  logic                  legal;
  logic [DATA_WIDTH-1:0] zext, sext;
  logic                  is_mem, misaligned, fault;
  logic [ADDR_WIDTH-1:0] addr;

  // One decoder serves both paths: the store operand while IDLE, the read data afterwards.
  assign ext_size = (state == IDLE) ? mem_operation_size : size_q;
  assign ext_data = (state == IDLE) ? r2_val : S_R_DATA;

  lsu_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
    .size   (ext_size),
    .data   (ext_data),
    .nbytes (nbytes),
    .legal  (legal),
    .zext   (zext),
    .sext   (sext)
  );

  assign is_mem     = (opcode == LOAD) || (opcode == STORE);
  assign misaligned = |(ex_res[2:0] & (nbytes[2:0] - 3'd1));
  assign fault      = is_mem && (!legal || misaligned);
  assign addr       = ADDR_WIDTH'(ex_res);

  assign S_R_ADDR_VALID = (state == RD_REQ);
  assign S_W_VALID      = (state == WR_REQ) && S_W_READY;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    case (state)
      IDLE: begin
        ready = !is_mem;
        if (is_mem) state_n = fault ? DONE : ((opcode == LOAD) ? RD_REQ : WR_REQ);
      end
      RD_REQ:  if (S_R_DATA_VALID) state_n = DONE;
      WR_REQ:  if (S_W_READY)      state_n = WR_WAIT;
      WR_WAIT: if (S_W_COMPLETE)   state_n = DONE;
      DONE: begin
        ready   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_enable  <= 1'b0;
      wb_dst_reg <= '0;
      wb_dst_val <= '0;
      ecall_wb   <= 1'b0;
      mem_fault  <= 1'b0;
      S_R_ADDR   <= '0;
      S_W_ADDR   <= '0;
      S_W_DATA   <= '0;
      S_W_SIZE   <= '0;
      size_q     <= '0;
      ld_dst     <= '0;
    end else begin
      wb_enable <= 1'b0;
      mem_fault <= 1'b0;
      ecall_wb  <= (state == IDLE) && (opcode > ALU) && ecall;
      case (state)
        IDLE: begin
          if (opcode == ALU) begin
            wb_enable  <= 1'b1;
            wb_dst_reg <= dst_reg;
            wb_dst_val <= ex_res;
          end else if (fault) begin
            mem_fault <= 1'b1;
          end else if (opcode == LOAD) begin
            S_R_ADDR <= addr;
            size_q   <= mem_operation_size;
            ld_dst   <= dst_reg;
          end else if (opcode == STORE) begin
            S_W_ADDR <= addr;
            S_W_DATA <= zext;
            S_W_SIZE <= nbytes;
          end
        end
        RD_REQ: begin
          if (S_R_DATA_VALID) begin
            wb_enable  <= 1'b1;
            wb_dst_reg <= ld_dst;
            wb_dst_val <= sext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_lsu.sv
// Randomized bench for pipeline_lsu with a transaction-level model and a bus responder.
module tb_pipeline_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic [6:0]  opcode = '0;
  logic [3:0]  mem_operation_size = '0;
  logic [63:0] ex_res = '0, r2_val = '0;
  logic [4:0]  dst_reg = '0;
  logic        ecall = 1'b0;
  logic        ready, wb_enable, ecall_wb, mem_fault;
  logic [4:0]  wb_dst_reg;
  logic [63:0] wb_dst_val;
  logic [63:0] s_r_addr, s_w_addr, s_w_data;
  logic        s_r_addr_valid, s_w_valid;
  logic [63:0] s_r_data = '0;
  logic        s_r_data_valid = 1'b0, s_w_ready = 1'b0, s_w_complete = 1'b0;
  logic [3:0]  s_w_size;

  pipeline_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_operation_size(mem_operation_size),
    .ex_res(ex_res), .r2_val(r2_val), .dst_reg(dst_reg), .ecall(ecall),
    .ready(ready), .wb_enable(wb_enable), .wb_dst_reg(wb_dst_reg), .wb_dst_val(wb_dst_val),
    .ecall_wb(ecall_wb), .mem_fault(mem_fault),
    .S_R_ADDR(s_r_addr), .S_R_ADDR_VALID(s_r_addr_valid), .S_R_DATA(s_r_data),
    .S_R_DATA_VALID(s_r_data_valid), .S_W_VALID(s_w_valid), .S_W_ADDR(s_w_addr),
    .S_W_DATA(s_w_data), .S_W_SIZE(s_w_size), .S_W_READY(s_w_ready), .S_W_COMPLETE(s_w_complete)
  );

  // 32-bit data build
  logic [6:0]  op32 = '0;
  logic [3:0]  sz32 = '0;
  logic [31:0] ex32 = '0, r2_32 = '0, rdata32 = '0;
  logic [4:0]  dst32 = '0;
  logic        rdy32, wb_en32, ecall_wb32, flt32, r_valid32, w_valid32;
  logic [4:0]  wb_reg32;
  logic [31:0] wb_val32, w_data32;
  logic [63:0] r_addr32, w_addr32;
  logic [3:0]  w_size32;
  logic        rdv32 = 1'b0;

  pipeline_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .opcode(op32), .mem_operation_size(sz32),
    .ex_res(ex32), .r2_val(r2_32), .dst_reg(dst32), .ecall(1'b0),
    .ready(rdy32), .wb_enable(wb_en32), .wb_dst_reg(wb_reg32), .wb_dst_val(wb_val32),
    .ecall_wb(ecall_wb32), .mem_fault(flt32),
    .S_R_ADDR(r_addr32), .S_R_ADDR_VALID(r_valid32), .S_R_DATA(rdata32),
    .S_R_DATA_VALID(rdv32), .S_W_VALID(w_valid32), .S_W_ADDR(w_addr32),
    .S_W_DATA(w_data32), .S_W_SIZE(w_size32), .S_W_READY(1'b1), .S_W_COMPLETE(1'b0)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [3:0] sz, input int dw);
    case (sz)
      4'd0, 4'd6: return 1;
      4'd1, 4'd5: return 2;
      4'd2, 4'd4: return 4;
      4'd3:       return (dw == 64) ? 8 : 0;
      default:    return 0;
    endcase
  endfunction

  // Called just after a negedge with the DUT in IDLE; returns at the negedge after retirement.
  task automatic do_op(input logic [6:0] op, input logic [3:0] sz, input logic [63:0] ea,
                       input logic [63:0] r2, input logic [4:0] rd, input logic ec,
                       input int rwait, input int wwait, input int cwait, input logic [63:0] rdata);
    int nb, k, ar_cnt, w_cnt, pulse_k, exp_cyc;
    bit is_mem, is_ld, is_st, flt, done;
    logic [63:0] mask, exp_ld;
    nb     = size_bytes(sz, 64);
    is_mem = (op == 7'd1) || (op == 7'd2);
    flt    = 1'b0;
    if (is_mem) begin
      if (nb == 0) flt = 1'b1;
      else if ((ea % 64'(nb)) != 64'd0) flt = 1'b1;
    end
    is_ld  = (op == 7'd1) && !flt;
    is_st  = (op == 7'd2) && !flt;
    mask   = (nb >= 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    exp_ld = rdata & mask;
    if (sz <= 4'd3 && nb > 0 && nb < 8 && exp_ld[8*nb-1]) exp_ld = exp_ld - (mask + 64'd1);
    exp_cyc = !is_mem ? 1 : flt ? 2 : is_ld ? 3 + rwait : 4 + wwait + cwait;

    opcode = op; mem_operation_size = sz; ex_res = ea; r2_val = r2; dst_reg = rd; ecall = ec;
    k = 0; ar_cnt = 0; w_cnt = 0; pulse_k = -1; done = 1'b0;
    while (!done) begin
      s_r_data       = {$urandom, $urandom};
      s_r_data_valid = 1'b0;
      if (s_r_addr_valid) begin
        chk("rd_addr", s_r_addr, ea);
        if (ar_cnt == rwait) begin s_r_data = rdata; s_r_data_valid = 1'b1; end
        ar_cnt++;
      end else s_r_data_valid = ($urandom_range(0, 3) == 0);
      if (op == 7'd2) s_w_ready = (k >= 1 + wwait);
      else            s_w_ready = 1'($urandom_range(0, 1));
      if (pulse_k >= 0) s_w_complete = (k == pulse_k + 1 + cwait);
      else              s_w_complete = ($urandom_range(0, 3) == 0);
      #1;
      if (s_w_valid) begin
        w_cnt++;
        pulse_k = k;
        chk("wr_addr", s_w_addr, ea);
        chk("wr_data", s_w_data, r2 & mask);
        chk("wr_size", s_w_size, nb);
      end
      if (ready) done = 1'b1;
      else if (k >= 40) begin
        chk("op_timeout", 64'(k), 64'(exp_cyc));
        done = 1'b1;
      end else begin
        k++;
        @(negedge clk);
      end
    end

    chk("cycles", 64'(k + 1), 64'(exp_cyc));
    if (is_mem) begin
      chk("fault_done", mem_fault, flt);
      chk("wb_en_done", wb_enable, is_ld);
      chk("rd_beats", 64'(ar_cnt), is_ld ? 64'(rwait + 1) : 64'd0);
      chk("wr_pulses", 64'(w_cnt), is_st ? 64'd1 : 64'd0);
      if (is_ld) begin
        chk("ld_val", wb_dst_val, exp_ld);
        chk("ld_reg", wb_dst_reg, rd);
      end
    end

    @(negedge clk);
    chk("wb_en_post", wb_enable, op == 7'd3);
    if (op == 7'd3) begin
      chk("alu_val", wb_dst_val, ea);
      chk("alu_reg", wb_dst_reg, rd);
    end
    chk("ecall_wb", ecall_wb, (op > 7'd3) && ec);
    chk("fault_post", mem_fault, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    s_w_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_wb_en", wb_enable, 1'b0);
    chk("rst_fault", mem_fault, 1'b0);
    chk("rst_ecall", ecall_wb, 1'b0);
    chk("rst_rvalid", s_r_addr_valid, 1'b0);
    chk("rst_wvalid", s_w_valid, 1'b0);
    chk("rst_raddr", s_r_addr, 64'd0);
    chk("rst_wb_val", wb_dst_val, 64'd0);
    chk("rst_ready", ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // directed cases
    do_op(7'd3, 4'd0, 64'h1234, 64'd0, 5'd5, 1'b0, 0, 0, 0, 64'd0);
    do_op(7'd1, 4'd0, 64'h841A1, 64'd0, 5'd7, 1'b0, 2, 0, 0, 64'h1122_3344_5566_7780);
    do_op(7'd1, 4'd6, 64'h841A1, 64'd0, 5'd8, 1'b0, 2, 0, 0, 64'h1122_3344_5566_7780);
    do_op(7'd2, 4'd2, 64'h100, 64'hAAAA_BBBB_CCCC_DDDD, 5'd0, 1'b0, 0, 2, 0, 64'd0);
    do_op(7'd1, 4'd2, 64'h102, 64'd0, 5'd3, 1'b0, 0, 0, 0, 64'hDEAD);
    do_op(7'd2, 4'd9, 64'h200, 64'h55, 5'd1, 1'b0, 0, 0, 0, 64'd0);
    do_op(7'd1, 4'd3, 64'h208, 64'd0, 5'd2, 1'b0, 0, 0, 0, 64'h8000_0000_0000_0001);
    do_op(7'd2, 4'd5, 64'h20E, 64'h1234_5678_9ABC_DEF0, 5'd1, 1'b0, 0, 0, 0, 64'd0);
    do_op(7'd45, 4'd0, 64'h0, 64'd0, 5'd0, 1'b1, 0, 0, 0, 64'd0);

    for (int i = 0; i < 300; i++) begin
      logic [6:0]  op;
      logic [3:0]  sz;
      logic [63:0] ea;
      int          nb, pick;
      pick = $urandom_range(0, 9);
      op = (pick < 4) ? 7'd1 : (pick < 7) ? 7'd2 : (pick < 8) ? 7'd3 :
           (pick < 9) ? 7'd0 : 7'($urandom_range(4, 127));
      sz = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      ea = {$urandom, $urandom};
      nb = size_bytes(sz, 64);
      if (nb > 0 && $urandom_range(0, 3) != 0) ea = ea & ~64'(nb - 1);
      do_op(op, sz, ea, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
    end

    // reset while a read is outstanding, then a late response
    opcode = 7'd1; mem_operation_size = 4'd3; ex_res = 64'h2000; dst_reg = 5'd9; ecall = 1'b0;
    s_r_data_valid = 1'b0; s_w_ready = 1'b0; s_w_complete = 1'b0;
    @(negedge clk);
    chk("mid_rd_req", s_r_addr_valid, 1'b1);
    reset = 1'b1; opcode = 7'd0;
    @(negedge clk);
    chk("mid_rvalid_low", s_r_addr_valid, 1'b0);
    chk("mid_wb_low", wb_enable, 1'b0);
    reset = 1'b0; s_r_data_valid = 1'b1; s_r_data = 64'h77;
    @(negedge clk);
    chk("late_wb_low", wb_enable, 1'b0);
    chk("late_ready", ready, 1'b1);
    chk("late_rvalid", s_r_addr_valid, 1'b0);
    s_r_data_valid = 1'b0;
    @(negedge clk);
    chk("late_wb_low2", wb_enable, 1'b0);

    // 32-bit build: doubleword is illegal, word load sign-extends within 32 bits
    op32 = 7'd1; sz32 = 4'd3; ex32 = 32'h10;
    #1 chk("d32_ld_ready", rdy32, 1'b0);
    @(negedge clk);
    chk("d32_ld_fault", flt32, 1'b1);
    chk("d32_ld_done_ready", rdy32, 1'b1);
    chk("d32_ld_no_rd", r_valid32, 1'b0);
    op32 = 7'd1; sz32 = 4'd2; ex32 = 32'h8000_0000; dst32 = 5'd3;
    @(negedge clk);
    chk("d32_lw_ready", rdy32, 1'b0);
    chk("d32_lw_nofault", flt32, 1'b0);
    @(negedge clk);
    chk("d32_lw_rvalid", r_valid32, 1'b1);
    chk("d32_lw_addr", r_addr32, 64'h8000_0000);
    rdata32 = 32'h8000_0000; rdv32 = 1'b1;
    @(negedge clk);
    op32 = 7'd0; rdv32 = 1'b0;
    chk("d32_lw_wb", wb_en32, 1'b1);
    chk("d32_lw_val", wb_val32, 64'h8000_0000);
    chk("d32_lw_reg", wb_reg32, 5'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
